// File: rtl/block_serial_subtractor_if.sv
// Handshake and operand/result bundle for block_serial_subtractor.
// Optional OP signal present only when BLOCK_SERIAL_SUBTRACTOR_ADD_MODE_EN is defined.
interface block_serial_subtractor_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  Bin;
`ifdef BLOCK_SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic                  OP;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] D;
    logic                  BF;
    logic                  OF;
    logic                  ZF;

    // Producer/consumer side driving operands and accepting results
    modport master (
`ifdef BLOCK_SERIAL_SUBTRACTOR_ADD_MODE_EN
        output OP,
`endif
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, BF, OF, ZF
    );

    // Arithmetic block side
    modport slave (
`ifdef BLOCK_SERIAL_SUBTRACTOR_ADD_MODE_EN
        input  OP,
`endif
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, BF, OF, ZF
    );
endinterface

// File: rtl/block_serial_subtractor.sv
// Multi-cycle subtractor: D = A - B - Bin, one BLOCK_SIZE-bit slice per clock
// with a registered borrow between slices, valid/ready on both sides.
// Optional macro BLOCK_SERIAL_SUBTRACTOR_ADD_MODE_EN adds an OP input
// (0 = subtract, 1 = add: D = A + B + Bin).
module block_serial_subtractor #(
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    block_serial_subtractor_if.slave bus
);

    localparam int STAGES = DATA_WIDTH / BLOCK_SIZE;
    localparam int CNT_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(STAGES - 1);

    if ((BLOCK_SIZE < 1) || (DATA_WIDTH < BLOCK_SIZE) || ((DATA_WIDTH % BLOCK_SIZE) != 0)) begin : g_bad_cfg
        $error("block_serial_subtractor: DATA_WIDTH must be a positive multiple of BLOCK_SIZE");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q;
    logic                  carry_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  a_msb_q;
    logic                  b_msb_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  bf_q;
    logic                  of_q;
    logic                  zf_q;
    logic                  add_mode;

`ifdef BLOCK_SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic                  add_q;
    assign add_mode = add_q;
`else
    assign add_mode = 1'b0;
`endif

    logic                  accept;
    logic                  last_slice;
    logic [BLOCK_SIZE-1:0] a_sl;
    logic [BLOCK_SIZE-1:0] b_sl;
    logic [BLOCK_SIZE-1:0] s_sl;
    logic                  c_sl;
    logic [DATA_WIDTH-1:0] acc_next;
    logic                  d_msb;
    logic                  bf_next;
    logic                  of_next;
    logic                  zf_next;

    assign accept     = bus.in_valid && (state_q == IDLE);
    assign last_slice = (state_q == RUN) && (cnt_q == LAST_SLICE);

    // Slice adder and flag computation for the slice currently at the bottom of the operand shifters
    always_comb begin
        a_sl = a_q[BLOCK_SIZE-1:0];
        b_sl = add_mode ? b_q[BLOCK_SIZE-1:0] : ~b_q[BLOCK_SIZE-1:0];
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{BLOCK_SIZE{1'b0}}, carry_q};
        // Result slices enter at the top and move down, so after STAGES slices
        // slice 0 sits at the bottom; written as shift/or so STAGES == 1 is legal.
        acc_next = (acc_q >> BLOCK_SIZE) | (DATA_WIDTH'(s_sl) << (DATA_WIDTH - BLOCK_SIZE));
        d_msb    = s_sl[BLOCK_SIZE-1];
        bf_next  = add_mode ? c_sl : ~c_sl;
        if (add_mode) begin
            of_next = (a_msb_q == b_msb_q) && (d_msb != a_msb_q);
        end else begin
            of_next = (a_msb_q != b_msb_q) && (d_msb != a_msb_q);
        end
        zf_next = (acc_next == '0);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept in IDLE, STAGES slice cycles in RUN, hold in DONE until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_SLICE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept, slice stepping during RUN, result/flag update on the last slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            acc_q   <= '0;
            d_q     <= '0;
            bf_q    <= 1'b0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
`ifdef BLOCK_SERIAL_SUBTRACTOR_ADD_MODE_EN
            add_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_q     <= bus.A;
                b_q     <= bus.B;
                a_msb_q <= bus.A[DATA_WIDTH-1];
                b_msb_q <= bus.B[DATA_WIDTH-1];
                cnt_q   <= '0;
`ifdef BLOCK_SERIAL_SUBTRACTOR_ADD_MODE_EN
                add_q   <= bus.OP;
                carry_q <= bus.OP ? bus.Bin : ~bus.Bin;
`else
                carry_q <= ~bus.Bin;
`endif
            end else if (state_q == RUN) begin
                a_q     <= a_q >> BLOCK_SIZE;
                b_q     <= b_q >> BLOCK_SIZE;
                carry_q <= c_sl;
                acc_q   <= acc_next;
                if (last_slice) begin
                    cnt_q <= '0;
                    d_q   <= acc_next;
                    bf_q  <= bf_next;
                    of_q  <= of_next;
                    zf_q  <= zf_next;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.D         = d_q;
    assign bus.BF        = bf_q;
    assign bus.OF        = of_q;
    assign bus.ZF        = zf_q;

endmodule
